// File: rtl/javk_alu_ctrl_pkg.sv
// javk_pkg: shared constants and types for the JAVK decoder/ALU block.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Contents: register indices, 16-bit register codes, ALU op and condition
// encodings, opcode match masks, flag struct and condition evaluator.
package javk_pkg;

  // 8-bit register file indices
  localparam logic [3:0] REG_Z = 4'd0;
  localparam logic [3:0] REG_A = 4'd1;
  localparam logic [3:0] REG_I = 4'd12;
  localparam logic [3:0] REG_J = 4'd13;
  localparam logic [3:0] REG_K = 4'd14;
  localparam logic [3:0] REG_L = 4'd15;

  // 16-bit register pair codes used by MVB
  localparam logic [1:0] R16_PC = 2'd0;
  localparam logic [1:0] R16_SP = 2'd1;
  localparam logic [1:0] R16_IJ = 2'd2;
  localparam logic [1:0] R16_KL = 2'd3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_CMP = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    CC_ALWAYS = 3'b000,
    CC_Z      = 3'b001,
    CC_NZ     = 3'b010,
    CC_C      = 3'b011,
    CC_NC     = 3'b100,
    CC_N      = 3'b101,
    CC_V      = 3'b110,
    CC_NEVER  = 3'b111
  } cond_t;

  // Flags packed so that the struct maps directly onto {V,N,C,Z} = [3:0]
  typedef struct packed {
    logic v;
    logic n;
    logic c;
    logic z;
  } flags_t;

  // Opcode classes: (instr & MASK) == VAL
  localparam logic [7:0] OPC_ALU_MASK = 8'h80;
  localparam logic [7:0] OPC_ALU_VAL  = 8'h80;
  localparam logic [7:0] OPC_NIB_MASK = 8'hE0;
  localparam logic [7:0] OPC_NIB_VAL  = 8'h40;
  localparam logic [7:0] OPC_LD_MASK  = 8'hF0;
  localparam logic [7:0] OPC_LD_VAL   = 8'h60;
  localparam logic [7:0] OPC_ST_MASK  = 8'hF0;
  localparam logic [7:0] OPC_ST_VAL   = 8'h70;
  localparam logic [7:0] OPC_MVA_MASK = 8'hF0;
  localparam logic [7:0] OPC_MVA_VAL  = 8'h30;
  localparam logic [7:0] OPC_MVB_MASK = 8'hF0;
  localparam logic [7:0] OPC_MVB_VAL  = 8'h20;
  localparam logic [7:0] OPC_JMP_MASK = 8'hF8;
  localparam logic [7:0] OPC_JMP_VAL  = 8'h00;
  localparam logic [7:0] OPC_JPL_MASK = 8'hF8;
  localparam logic [7:0] OPC_JPL_VAL  = 8'h08;

  function automatic logic cond_eval(input cond_t cc, input flags_t f);
    logic res;
    case (cc)
      CC_ALWAYS: res = 1'b1;
      CC_Z:      res = f.z;
      CC_NZ:     res = ~f.z;
      CC_C:      res = f.c;
      CC_NC:     res = ~f.c;
      CC_N:      res = f.n;
      CC_V:      res = f.v;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/javk_alu_ctrl_if.sv
// javk_alu_ctrl_if: bus between the JAVK core and its decoder/ALU block.
// Latency: n/a (wires only).
// Backpressure: none; the core samples strobes every posedge.
// master = core (drives instr/a/b), slave = javk_alu_ctrl (drives the rest).
interface javk_alu_ctrl_if;
  logic [7:0] instr;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic       alu_wr;
  logic [3:0] reg_sel;
  logic [3:0] addr_offset;
  logic       fetch;
  logic       we;
  logic       jmp;
  logic       jpl;
  logic       branch;
  logic       mva;
  logic       mvb;
  logic [1:0] reg16_src;
  logic [1:0] reg16_dst;
  logic       nibble_read;
  logic       nibble_hl;
  logic [3:0] nibble_out;

  modport master (
    output instr, a, b,
    input  alu_out, alu_flags, alu_wr, reg_sel, addr_offset, fetch, we,
           jmp, jpl, branch, mva, mvb, reg16_src, reg16_dst,
           nibble_read, nibble_hl, nibble_out
  );

  modport slave (
    input  instr, a, b,
    output alu_out, alu_flags, alu_wr, reg_sel, addr_offset, fetch, we,
           jmp, jpl, branch, mva, mvb, reg16_src, reg16_dst,
           nibble_read, nibble_hl, nibble_out
  );
endinterface

// File: rtl/javk_alu_ctrl_alu.sv
// javk_alu: combinational 8-bit ALU result and {V,N,C,Z} flag computation.
// Latency: 0 (pure combinational; the caller registers the outputs).
// Backpressure: n/a.
// Ports: i_op op select, i_a/i_b operands, i_shamt shift amount,
// i_cin carry-in (used by ADD/SUB only), o_result, o_flags.
module javk_alu
  import javk_pkg::*;
(
  input  alu_op_t    i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [3:0] i_shamt,
  input  logic       i_cin,
  output logic [7:0] o_result,
  output flags_t     o_flags
);

  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic [8:0]  w_cmp;
  logic [15:0] w_shl;
  logic [15:0] w_shr;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
  // Bit 8 of a 9-bit difference is the unsigned borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {8'd0, i_cin};
  assign w_cmp  = {1'b0, i_a} - {1'b0, i_b};
  // Widened shifts: the bit landing just outside the result is the last bit
  // shifted out. It is naturally 0 for shamt=0 and for shamt>8.
  assign w_shl  = {8'd0, i_a} << i_shamt;
  assign w_shr  = {i_a, 8'd0} >> i_shamt;

  always_comb begin
    o_result = 8'd0;
    o_flags  = '0;
    case (i_op)
      ALU_ADD: begin
        o_result  = w_sum[7:0];
        o_flags.c = w_sum[8];
        o_flags.v = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
      end
      ALU_SUB: begin
        o_result  = w_diff[7:0];
        o_flags.c = w_diff[8];
        o_flags.v = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
      end
      ALU_CMP: begin
        o_result  = w_cmp[7:0];
        o_flags.c = w_cmp[8];
        o_flags.v = (i_a[7] != i_b[7]) && (w_cmp[7] != i_a[7]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SHL: begin
        o_result  = w_shl[7:0];
        o_flags.c = w_shl[8];
      end
      ALU_SHR: begin
        o_result  = w_shr[15:8];
        o_flags.c = w_shr[7];
      end
      default: o_result = 8'd0;
    endcase
    o_flags.z = (o_result == 8'd0);
    o_flags.n = o_result[7];
  end

endmodule

// File: rtl/javk_alu_ctrl.sv
// javk_alu_ctrl: JAVK instruction decoder plus registered 8-bit ALU.
// Latency: decode/branch combinational from instr; alu_out/flags/alu_wr 1 cycle.
// Backpressure: none; a new instruction is accepted every cycle.
// Ports: clk, rst (sync, active-high); bus = javk_alu_ctrl_if.slave.
// Build option: define JAVK_ADC_EN to make ADD/SUB consume the registered carry.
module javk_alu_ctrl
  import javk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  javk_alu_ctrl_if.slave bus
);

  logic [7:0] r_alu_out;
  flags_t     r_flags;
  logic       r_alu_wr;

  logic       w_is_alu;
  alu_op_t    w_op;
  logic [3:0] w_reg_sel;
  logic [3:0] w_addr_offset;
  logic       w_fetch;
  logic       w_we;
  logic       w_jmp;
  logic       w_jpl;
  logic       w_mva;
  logic       w_mvb;
  logic [1:0] w_reg16_src;
  logic [1:0] w_reg16_dst;
  logic       w_nib_rd;
  logic       w_nib_hl;
  logic [3:0] w_nib_out;
  logic       w_cond;
  logic       w_cin;
  logic [7:0] w_result;
  flags_t     w_flags;

  assign w_op = alu_op_t'(bus.instr[6:4]);

`ifdef JAVK_ADC_EN
  assign w_cin = r_flags.c;
`else
  assign w_cin = 1'b0;
`endif

  // Decoder: one opcode class is active at a time; fields of other classes stay 0.
  always_comb begin
    w_is_alu      = 1'b0;
    w_reg_sel     = 4'd0;
    w_addr_offset = 4'd0;
    w_fetch       = 1'b0;
    w_we          = 1'b0;
    w_jmp         = 1'b0;
    w_jpl         = 1'b0;
    w_mva         = 1'b0;
    w_mvb         = 1'b0;
    w_reg16_src   = 2'd0;
    w_reg16_dst   = 2'd0;
    w_nib_rd      = 1'b0;
    w_nib_hl      = 1'b0;
    w_nib_out     = 4'd0;
    if ((bus.instr & OPC_ALU_MASK) == OPC_ALU_VAL) begin
      w_is_alu  = 1'b1;
      w_reg_sel = bus.instr[3:0];
    end else if ((bus.instr & OPC_NIB_MASK) == OPC_NIB_VAL) begin
      w_nib_rd  = 1'b1;
      w_nib_hl  = bus.instr[4];
      w_nib_out = bus.instr[3:0];
    end else if ((bus.instr & OPC_LD_MASK) == OPC_LD_VAL) begin
      w_fetch       = 1'b1;
      w_addr_offset = bus.instr[3:0];
    end else if ((bus.instr & OPC_ST_MASK) == OPC_ST_VAL) begin
      w_fetch       = 1'b1;
      w_we          = 1'b1;
      w_addr_offset = bus.instr[3:0];
    end else if ((bus.instr & OPC_MVA_MASK) == OPC_MVA_VAL) begin
      w_reg_sel = bus.instr[3:0];
      // Copying A onto itself or onto the zero register is a no-op.
      w_mva     = (bus.instr[3:0] != REG_A) && (bus.instr[3:0] != REG_Z);
    end else if ((bus.instr & OPC_MVB_MASK) == OPC_MVB_VAL) begin
      w_mvb       = 1'b1;
      w_reg16_src = bus.instr[3:2];
      w_reg16_dst = bus.instr[1:0];
    end else if ((bus.instr & OPC_JMP_MASK) == OPC_JMP_VAL) begin
      w_jmp = 1'b1;
    end else if ((bus.instr & OPC_JPL_MASK) == OPC_JPL_VAL) begin
      w_jpl = 1'b1;
    end
  end

  // Uses registered flags, so an ALU op right before a jump is already visible.
  assign w_cond = cond_eval(cond_t'(bus.instr[2:0]), r_flags);

  javk_alu u_alu (
    .i_op     (w_op),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_shamt  (bus.instr[3:0]),
    .i_cin    (w_cin),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out <= 8'd0;
      r_flags   <= '0;
      r_alu_wr  <= 1'b0;
    end else if (w_is_alu) begin
      r_flags <= w_flags;
      if (w_op != ALU_CMP) begin
        r_alu_out <= w_result;
        r_alu_wr  <= 1'b1;
      end else begin
        r_alu_wr  <= 1'b0;
      end
    end else begin
      r_alu_wr <= 1'b0;
    end
  end

  assign bus.alu_out     = r_alu_out;
  assign bus.alu_flags   = r_flags;
  assign bus.alu_wr      = r_alu_wr;
  assign bus.reg_sel     = w_reg_sel;
  assign bus.addr_offset = w_addr_offset;
  assign bus.reg16_src   = w_reg16_src;
  assign bus.reg16_dst   = w_reg16_dst;
  assign bus.nibble_hl   = w_nib_hl;
  assign bus.nibble_out  = w_nib_out;
  // Strobes are held low during reset so the core takes no action.
  assign bus.fetch       = w_fetch  & ~rst;
  assign bus.we          = w_we     & ~rst;
  assign bus.jmp         = w_jmp    & ~rst;
  assign bus.jpl         = w_jpl    & ~rst;
  assign bus.branch      = (w_jmp | w_jpl) & w_cond & ~rst;
  assign bus.mva         = w_mva    & ~rst;
  assign bus.mvb         = w_mvb    & ~rst;
  assign bus.nibble_read = w_nib_rd & ~rst;

endmodule

// File: tb/tb_javk_alu_ctrl.sv
// tb_javk_alu_ctrl: directed self-checking bench for javk_alu_ctrl.
// Inputs change on negedge (as the core latches instr); decode is checked #1
// later, registered ALU outputs are checked #1 after the following posedge.
module tb_javk_alu_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  javk_alu_ctrl_if bus ();

  javk_alu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Apply one instruction on the negedge and let decode settle.
  task automatic drive(input logic [7:0] ins, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.instr = ins;
    bus.a     = av;
    bus.b     = bv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_alu(input string tag, input logic [7:0] o, input logic [3:0] f,
                         input logic w);
    chk({tag, ".out"}, bus.alu_out, o);
    chk({tag, ".flags"}, {4'd0, bus.alu_flags}, {4'd0, f});
    chk({tag, ".wr"}, {7'd0, bus.alu_wr}, {7'd0, w});
  endtask

  logic [7:0] exp_adc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst       = 1'b1;
    bus.instr = 8'h01;
    bus.a     = 8'h7F;
    bus.b     = 8'h01;
    #1;
    // Reset: strobes forced low even for a valid jump
    chk("rst.jmp", {7'd0, bus.jmp}, 8'd0);
    chk("rst.branch", {7'd0, bus.branch}, 8'd0);
    bus.instr = 8'h80;
    tick();
    chk_alu("rst", 8'h00, 4'h0, 1'b0);
    drive(8'h73, 8'h7F, 8'h01);
    chk("rst.fetch", {7'd0, bus.fetch}, 8'd0);
    chk("rst.we", {7'd0, bus.we}, 8'd0);
    bus.instr = 8'h80;
    tick();
    chk_alu("rst2", 8'h00, 4'h0, 1'b0);

    // ADD 0x7F+0x01: signed overflow into negative
    drive(8'h82, 8'h7F, 8'h01);
    rst = 1'b0;
    #1;
    chk("add.reg_sel", {4'd0, bus.reg_sel}, 8'h02);
    tick();
    chk_alu("add", 8'h80, 4'b1100, 1'b1);
    drive(8'h01, 8'h00, 8'h00);
    chk("jmpz.jmp", {7'd0, bus.jmp}, 8'd1);
    chk("jmpz.branch", {7'd0, bus.branch}, 8'd0);
    tick();
    chk_alu("jmp_hold", 8'h80, 4'b1100, 1'b0);

    // CMP equal: Z set, alu_out kept
    drive(8'hD3, 8'h05, 8'h05);
    tick();
    chk_alu("cmp", 8'h80, 4'b0001, 1'b0);
    drive(8'h09, 8'h00, 8'h00);
    chk("jplz.jpl", {7'd0, bus.jpl}, 8'd1);
    chk("jplz.branch", {7'd0, bus.branch}, 8'd1);
    drive(8'h02, 8'h00, 8'h00);
    chk("jmpnz.branch", {7'd0, bus.branch}, 8'd0);
    drive(8'h07, 8'h00, 8'h00);
    chk("jmpnever.branch", {7'd0, bus.branch}, 8'd0);
    drive(8'h39, 8'h00, 8'h00);
    chk("mva.branch", {7'd0, bus.branch}, 8'd0);

    // Shifts and boundaries
    drive(8'hE1, 8'h81, 8'h00);
    tick();
    chk_alu("shl1", 8'h02, 4'b0010, 1'b1);
    drive(8'h03, 8'h00, 8'h00);
    chk("jmpc.branch", {7'd0, bus.branch}, 8'd1);
    drive(8'hF9, 8'h81, 8'h00);
    tick();
    chk_alu("shr9", 8'h00, 4'b0001, 1'b1);
    drive(8'hF1, 8'h81, 8'h00);
    tick();
    chk_alu("shr1", 8'h40, 4'b0010, 1'b1);
    drive(8'hE8, 8'h81, 8'h00);
    tick();
    chk_alu("shl8", 8'h00, 4'b0011, 1'b1);
    drive(8'hE0, 8'h81, 8'h00);
    tick();
    chk_alu("shl0", 8'h81, 4'b0100, 1'b1);

    // SUB with borrow (carry-in is 0 here), then signed overflow
    drive(8'h90, 8'h03, 8'h05);
    tick();
    chk_alu("sub_borrow", 8'hFE, 4'b0110, 1'b1);
    // C=1 now: ADD 1+1 uses carry-in only when the option is built in
`ifdef JAVK_ADC_EN
    exp_adc = 8'h03;
`else
    exp_adc = 8'h02;
`endif
    drive(8'h80, 8'h01, 8'h01);
    tick();
    chk_alu("add_cin", exp_adc, 4'b0000, 1'b1);
    drive(8'h90, 8'h80, 8'h01);
    tick();
    chk_alu("sub_ovf", 8'h7F, 4'b1000, 1'b1);

    // Logic ops clear C and V
    drive(8'hA0, 8'hF0, 8'h3C);
    tick();
    chk_alu("and", 8'h30, 4'b0000, 1'b1);
    drive(8'hC0, 8'hF0, 8'h3C);
    tick();
    chk_alu("xor", 8'hCC, 4'b0100, 1'b1);

    // Non-ALU decodes; alu_out/flags must hold
    drive(8'h31, 8'h00, 8'h00);
    chk("mvaA.mva", {7'd0, bus.mva}, 8'd0);
    chk("mvaA.reg_sel", {4'd0, bus.reg_sel}, 8'h01);
    drive(8'h3C, 8'h00, 8'h00);
    chk("mvaI.mva", {7'd0, bus.mva}, 8'd1);
    chk("mvaI.reg_sel", {4'd0, bus.reg_sel}, 8'd12);
    drive(8'h2B, 8'h00, 8'h00);
    chk("mvb.mvb", {7'd0, bus.mvb}, 8'd1);
    chk("mvb.src", {6'd0, bus.reg16_src}, 8'd2);
    chk("mvb.dst", {6'd0, bus.reg16_dst}, 8'd3);
    drive(8'h5A, 8'h00, 8'h00);
    chk("nib.read", {7'd0, bus.nibble_read}, 8'd1);
    chk("nib.hl", {7'd0, bus.nibble_hl}, 8'd1);
    chk("nib.out", {4'd0, bus.nibble_out}, 8'h0A);
    drive(8'h73, 8'h00, 8'h00);
    chk("st.fetch", {7'd0, bus.fetch}, 8'd1);
    chk("st.we", {7'd0, bus.we}, 8'd1);
    chk("st.offset", {4'd0, bus.addr_offset}, 8'h03);
    drive(8'h64, 8'h00, 8'h00);
    chk("ld.fetch", {7'd0, bus.fetch}, 8'd1);
    chk("ld.we", {7'd0, bus.we}, 8'd0);
    chk("ld.offset", {4'd0, bus.addr_offset}, 8'h04);
    drive(8'h1F, 8'hFF, 8'hFF);
    chk("nop.strobes", {bus.fetch, bus.we, bus.jmp, bus.jpl, bus.mva, bus.mvb,
                        bus.nibble_read, bus.branch}, 8'h00);
    tick();
    chk_alu("nonalu_hold", 8'hCC, 4'b0100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
